// File: rtl/zeroriscy_dbus_arb.sv
// Round-robin two-master arbiter for the OBI data bus in front of the SRAM data port.
// Keeps an in-order owner FIFO so each response is routed back to the master that issued it.
module zeroriscy_dbus_arb #(
    parameter int MAX_OUT = 2,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [3:0]    m0_be,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [3:0]    m1_be,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic          m1_err,
    output logic          s_req,
    output logic          s_we,
    output logic [3:0]    s_be,
    output logic [AW-1:0] s_addr,
    output logic [31:0]   s_wdata,
    input  logic          s_gnt,
    input  logic          s_rvalid,
    input  logic [31:0]   s_rdata,
    input  logic          s_err,
    output logic          protocol_err
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [CW-1:0]      count;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [MAX_OUT-1:0] owner;
    logic               last;
    logic               lock;
    logic               lock_id;
    logic               err_q;

    logic sel_id;
    logic sel_req;
    logic not_full;
    logic hs;
    logic head;
    logic pop;
    logic orphan;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
    endfunction

    // A locked master keeps the bus until its stalled request is accepted.
    always_comb begin
        sel_id = 1'b0;
        if (lock) begin
            sel_id = lock_id;
        end else if (m0_req && m1_req) begin
            sel_id = ~last;
        end else if (m1_req) begin
            sel_id = 1'b1;
        end
    end

    assign sel_req  = sel_id ? m1_req : m0_req;
    assign not_full = (count < CW'(MAX_OUT));
    assign s_req    = rst_n & sel_req & not_full;
    assign s_we     = sel_id ? m1_we    : m0_we;
    assign s_be     = sel_id ? m1_be    : m0_be;
    assign s_addr   = sel_id ? m1_addr  : m0_addr;
    assign s_wdata  = sel_id ? m1_wdata : m0_wdata;

    assign hs     = s_req & s_gnt;
    assign m0_gnt = hs & ~sel_id;
    assign m1_gnt = hs & sel_id;

    assign head      = owner[rd_ptr];
    assign pop       = s_rvalid & (count != '0);
    assign orphan    = s_rvalid & (count == '0);
    assign m0_rvalid = rst_n & pop & ~head;
    assign m1_rvalid = rst_n & pop & head;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign m0_err    = s_err;
    assign m1_err    = s_err;

    assign protocol_err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            owner   <= '0;
            last    <= 1'b1;
            lock    <= 1'b0;
            lock_id <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (hs) begin
                owner[wr_ptr] <= sel_id;
                wr_ptr        <= ptr_inc(wr_ptr);
                last          <= sel_id;
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({hs, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            lock <= s_req & ~s_gnt;
            if (s_req && !s_gnt) begin
                lock_id <= sel_id;
            end
            if (orphan) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
